// File: rtl/psum_deskew_accum_pkg.sv
// Shared constants and column-slicing helpers for the partial-sum deskew/accumulate path.
// The array's input skew logic uses the same helpers.
package psum_deskew_accum_pkg;
  localparam int SYSTOLIC_SIZE_D     = 8;
  localparam int PARTIAL_SUM_WIDTH_D = 19;
  localparam int ACC_WIDTH_D         = 32;
  localparam int ACC_DEPTH_D         = 16;

  function automatic int deskew_lat(input int n);
    return n - 1;
  endfunction

  localparam int DESKEW_LAT = deskew_lat(SYSTOLIC_SIZE_D);

  // Low bit of column col in a flat bus of w-bit columns.
  function automatic int col_lo(input int col, input int w);
    return col * w;
  endfunction
endpackage

// File: rtl/psum_deskew_accum_deskew.sv
// Triangular per-lane delay line plus sideband delay: lane j lags lane 0 by j cycles
// on input and all lanes leave together from the align register.
module psum_deskew_lane #(
  parameter int DEPTH = 1,
  parameter int W     = 19
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [DEPTH-1:0][W-1:0] dly;

  if (DEPTH == 1) begin : g_one
    always_ff @(posedge clk) begin
      if (rst) dly[0] <= '0;
      else     dly[0] <= d;
    end
  end else begin : g_shift
    always_ff @(posedge clk) begin
      if (rst) dly <= '0;
      else     dly <= {dly[DEPTH-2:0], d};
    end
  end

  assign q = dly[DEPTH-1];
endmodule

module psum_deskew
  import psum_deskew_accum_pkg::*;
#(
  parameter int NUM_LANES = 8,
  parameter int LANE_W    = 19,
  parameter int SIDE_W    = 6
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          valid,
  input  logic [SIDE_W-1:0]             side,
  input  logic [NUM_LANES*LANE_W-1:0]   data,
  output logic                          aligned_valid,
  output logic [SIDE_W-1:0]             aligned_side,
  output logic [NUM_LANES*LANE_W-1:0]   aligned_data
);
  // Top index of the pipe is the align register; the rest are delay stages.
  localparam int STAGES = deskew_lat(NUM_LANES);

  logic [STAGES:0]             vld_pipe;
  logic [STAGES:0][SIDE_W-1:0] side_pipe;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe  <= '0;
      side_pipe <= '0;
    end else begin
      vld_pipe  <= {vld_pipe[STAGES-1:0], valid};
      side_pipe <= {side_pipe[STAGES-1:0], side};
    end
  end

  assign aligned_valid = vld_pipe[STAGES];
  assign aligned_side  = side_pipe[STAGES];

  for (genvar j = 0; j < NUM_LANES; j++) begin : g_lane
    psum_deskew_lane #(.DEPTH(NUM_LANES - j), .W(LANE_W)) u_lane (
      .clk (clk),
      .rst (rst),
      .d   (data[j*LANE_W +: LANE_W]),
      .q   (aligned_data[j*LANE_W +: LANE_W])
    );
  end
endmodule

// File: rtl/psum_deskew_accum.sv
// Realigns skewed systolic-array bottom-row outputs, accumulates them per row entry
// across K tiles, and emits completed rows through a 2-entry valid/ready FIFO.
module psum_deskew_accum
  import psum_deskew_accum_pkg::*;
#(
  parameter int SYSTOLIC_SIZE     = SYSTOLIC_SIZE_D,
  parameter int PARTIAL_SUM_WIDTH = PARTIAL_SUM_WIDTH_D,
  parameter int ACC_WIDTH         = ACC_WIDTH_D,
  parameter int ACC_DEPTH         = ACC_DEPTH_D,
  parameter int ADDR_WIDTH        = $clog2(ACC_DEPTH)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  input  logic                                 in_first,
  input  logic                                 in_last,
  input  logic [ADDR_WIDTH-1:0]                in_addr,
  input  logic [SYSTOLIC_SIZE*PARTIAL_SUM_WIDTH-1:0] partial_sum_flat,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [ADDR_WIDTH-1:0]                out_addr,
  output logic [SYSTOLIC_SIZE*ACC_WIDTH-1:0]   out_data_flat,
  output logic                                 overflow_err
);
  localparam int N = SYSTOLIC_SIZE;

  typedef struct packed {
    logic                  first;
    logic                  last;
    logic [ADDR_WIDTH-1:0] addr;
  } side_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]         addr;
    logic [N-1:0][ACC_WIDTH-1:0]   row;
  } ent_t;

  side_t                             in_side, al_side;
  logic                              al_valid;
  logic [N*PARTIAL_SUM_WIDTH-1:0]    al_data;

  assign in_side = {in_first, in_last, in_addr};

  psum_deskew #(
    .NUM_LANES (N),
    .LANE_W    (PARTIAL_SUM_WIDTH),
    .SIDE_W    ($bits(side_t))
  ) u_deskew (
    .clk           (clk),
    .rst           (rst),
    .valid         (in_valid),
    .side          (in_side),
    .data          (partial_sum_flat),
    .aligned_valid (al_valid),
    .aligned_side  (al_side),
    .aligned_data  (al_data)
  );

  // Single-cycle read-modify-write: the next row to the same entry sees this result.
  logic [N-1:0][ACC_WIDTH-1:0] acc [ACC_DEPTH];
  logic [N-1:0][ACC_WIDTH-1:0] new_row;

  always_comb begin
    new_row = '0;
    for (int i = 0; i < N; i++) begin
      new_row[i] = (al_side.first ? '0 : acc[al_side.addr][i])
                 + ACC_WIDTH'($signed(al_data[col_lo(i, PARTIAL_SUM_WIDTH) +: PARTIAL_SUM_WIDTH]));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int e = 0; e < ACC_DEPTH; e++) acc[e] <= '0;
    end else if (al_valid) begin
      acc[al_side.addr] <= new_row;
    end
  end

  ent_t       fifo [2];
  logic       wptr, rptr;
  logic [1:0] count;
  logic       push, pop, full, accept;

  assign push   = al_valid & al_side.last;
  assign pop    = out_valid & out_ready;
  assign full   = (count == 2'd2);
  assign accept = push & (~full | pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) fifo[k] <= '0;
      wptr         <= 1'b0;
      rptr         <= 1'b0;
      count        <= 2'd0;
      overflow_err <= 1'b0;
    end else begin
      if (accept) begin
        fifo[wptr] <= '{addr: al_side.addr, row: new_row};
        wptr       <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      count <= count + 2'(accept) - 2'(pop);
      if (push & full & ~pop) overflow_err <= 1'b1;
    end
  end

  assign out_valid     = (count != 2'd0);
  assign out_addr      = fifo[rptr].addr;
  assign out_data_flat = fifo[rptr].row;
endmodule

// File: tb/tb_psum_deskew_accum.sv
// Bench for psum_deskew_accum: table vectors, hand-written corner sequences and a
// randomized run, all compared against an event-level queue model of the block.
module tb_psum_deskew_accum;
  localparam int N  = 8;
  localparam int PW = 19;
  localparam int AW = 32;
  localparam int HN = 4096;

  logic            clk = 1'b0;
  logic            rst, in_valid, in_first, in_last, out_ready;
  logic [3:0]      in_addr;
  logic [N*PW-1:0] partial_sum_flat;
  logic            out_valid, overflow_err;
  logic [3:0]      out_addr;
  logic [N*AW-1:0] out_data_flat;

  psum_deskew_accum dut (
    .clk (clk), .rst (rst),
    .in_valid (in_valid), .in_first (in_first), .in_last (in_last), .in_addr (in_addr),
    .partial_sum_flat (partial_sum_flat),
    .out_valid (out_valid), .out_ready (out_ready), .out_addr (out_addr),
    .out_data_flat (out_data_flat), .overflow_err (overflow_err)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0, total_cnt = 0;
  int cyc = 0;
  int hist [HN][N];
  int cur_vals [N];

  // Reference model: accumulator contents, pending completed rows, output FIFO contents.
  typedef struct { int due; logic [3:0] addr; int row [N]; } pend_t;
  typedef struct { logic [3:0] addr; int row [N]; } ent_t;
  pend_t pq [$];
  ent_t  mq [$];
  int    macc [16][N];
  bit    movf;

  typedef struct { logic [3:0] addr; int tiles; int val; int step; int exp0; int estep; } vec_t;
  vec_t tbl [6];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
  endtask

  function automatic logic [255:0] flat(input int e0, input int es);
    logic [255:0] f = '0;
    for (int i = 0; i < N; i++) f[i*AW +: AW] = e0 + i*es;
    return f;
  endfunction

  function automatic int rand_ps();
    int r = int'($urandom_range(0, (1 << PW) - 1));
    return (r >= (1 << (PW-1))) ? r - (1 << PW) : r;
  endfunction

  task automatic tick();
    int t;
    for (int j = 0; j < N; j++) hist[cyc % HN][j] = cur_vals[j];
    for (int j = 0; j < N; j++) begin
      t = (cyc - j >= 0) ? hist[(cyc - j) % HN][j] : 0;
      partial_sum_flat[j*PW +: PW] = t[PW-1:0];
    end
    if (in_valid && !rst) begin
      pend_t p;
      p.due = cyc + N; p.addr = in_addr;
      for (int i = 0; i < N; i++) begin
        p.row[i] = (in_first ? 0 : macc[in_addr][i]) + cur_vals[i];
        macc[in_addr][i] = p.row[i];
      end
      if (in_last) pq.push_back(p);
    end
    if (rst) begin
      mq.delete(); pq.delete(); movf = 0;
      for (int e = 0; e < 16; e++) for (int i = 0; i < N; i++) macc[e][i] = 0;
    end else begin
      if (mq.size() > 0 && out_ready) void'(mq.pop_front());
      if (pq.size() > 0 && pq[0].due == cyc) begin
        pend_t p = pq.pop_front();
        ent_t  e;
        e.addr = p.addr; e.row = p.row;
        if (mq.size() < 2) mq.push_back(e);
        else movf = 1;
      end
    end
    @(posedge clk); #1;
    cyc++;
    chk("model_out_valid", out_valid, mq.size() != 0);
    chk("model_overflow", overflow_err, movf);
    if (mq.size() != 0) begin
      logic [255:0] f = '0;
      for (int i = 0; i < N; i++) f[i*AW +: AW] = mq[0].row[i];
      chk("model_out_addr", out_addr, mq[0].addr);
      chk("model_out_data", out_data_flat, f);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      in_valid = 0; in_first = 0; in_last = 0; in_addr = 4'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) cur_vals[i] = rand_ps();
      tick();
    end
  endtask

  task automatic row(input logic [3:0] a, input bit f, input bit l, input int val, input int step);
    in_valid = 1; in_first = f; in_last = l; in_addr = a;
    for (int i = 0; i < N; i++) cur_vals[i] = val + i*step;
    tick();
    in_valid = 0; in_first = 0; in_last = 0;
  endtask

  task automatic do_reset();
    rst = 1; idle(2); rst = 0;
  endtask

  initial begin
    tbl[0] = '{addr: 3,  tiles: 1, val: 1,       step: 1,  exp0: 1,       estep: 1};
    tbl[1] = '{addr: 5,  tiles: 3, val: -2,      step: 0,  exp0: -6,      estep: 0};
    tbl[2] = '{addr: 7,  tiles: 4, val: 10,      step: 0,  exp0: 40,      estep: 0};
    tbl[3] = '{addr: 15, tiles: 2, val: 262143,  step: 0,  exp0: 524286,  estep: 0};
    tbl[4] = '{addr: 0,  tiles: 2, val: -262144, step: 0,  exp0: -524288, estep: 0};
    tbl[5] = '{addr: 9,  tiles: 1, val: -1,      step: -1, exp0: -1,      estep: -1};

    rst = 1; in_valid = 0; in_first = 0; in_last = 0; in_addr = 0; out_ready = 1;
    partial_sum_flat = '0;
    for (int i = 0; i < N; i++) cur_vals[i] = 0;
    #1;
    do_reset();
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_addr", out_addr, 0);
    chk("reset_out_data", out_data_flat, 0);
    chk("reset_overflow", overflow_err, 0);

    // Table vectors: multi-tile rows, exact latency from the last tile.
    for (int v = 0; v < 6; v++) begin
      for (int t = 0; t < tbl[v].tiles; t++)
        row(tbl[v].addr, t == 0, t == tbl[v].tiles - 1, tbl[v].val, tbl[v].step);
      idle(N - 1);
      chk("tbl_early_valid", out_valid, 0);
      idle(1);
      chk("tbl_out_valid", out_valid, 1);
      chk("tbl_out_addr", out_addr, tbl[v].addr);
      chk("tbl_out_data", out_data_flat, flat(tbl[v].exp0, tbl[v].estep));
      idle(3);
    end

    // Interleaved back-to-back rows to two entries.
    for (int t = 0; t < 4; t++) begin
      row(0, t == 0, t == 3, 10, 0);
      row(1, t == 0, t == 3, 10, 0);
    end
    idle(N - 1);
    chk("alt_addr0", out_addr, 0);
    chk("alt_data0", out_data_flat, flat(40, 0));
    idle(1);
    chk("alt_addr1", out_addr, 1);
    chk("alt_data1", out_data_flat, flat(40, 0));
    idle(3);

    // Full FIFO with a pop in the same cycle as the third push.
    out_ready = 0;
    row(1, 1, 1, 3, 0); row(2, 1, 1, 4, 0); row(4, 1, 1, 5, 0);
    idle(N - 1);
    chk("full_head", out_addr, 1);
    out_ready = 1;
    idle(1);
    chk("full_pop_noovf", overflow_err, 0);
    chk("full_pop_head", out_addr, 2);
    idle(1);
    chk("full_pop_third", out_addr, 4);
    chk("full_pop_third_data", out_data_flat, flat(5, 0));
    idle(1);
    chk("full_pop_empty", out_valid, 0);
    idle(2);

    // Congested output: third row is dropped and the error is sticky.
    out_ready = 0;
    row(2, 1, 1, 11, 0); row(4, 1, 1, 12, 0); row(6, 1, 1, 13, 0);
    idle(N);
    chk("ovf_set", overflow_err, 1);
    chk("ovf_head", out_addr, 2);
    idle(3);
    chk("ovf_sticky", overflow_err, 1);
    chk("ovf_hold_data", out_data_flat, flat(11, 0));
    out_ready = 1;
    idle(1);
    chk("ovf_second", out_addr, 4);
    idle(1);
    chk("ovf_drained", out_valid, 0);
    chk("ovf_still_set", overflow_err, 1);
    do_reset();
    chk("ovf_cleared", overflow_err, 0);

    // Reset while a row is in flight.
    row(11, 1, 1, 5, 0);
    idle(2);
    rst = 1; idle(1); rst = 0;
    for (int k = 0; k < N + 4; k++) begin
      idle(1);
      chk("rst_mid_no_out", out_valid, 0);
    end
    row(11, 0, 1, 7, 0);
    idle(N);
    chk("rst_mid_addr", out_addr, 11);
    chk("rst_mid_data", out_data_flat, flat(7, 0));
    idle(3);

    // Randomized traffic.
    for (int k = 0; k < 500; k++) begin
      rst       = ($urandom_range(0, 199) == 0);
      in_valid  = !rst && $urandom_range(0, 1);
      in_first  = ($urandom_range(0, 2) == 0);
      in_last   = ($urandom_range(0, 2) == 0);
      in_addr   = 4'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) cur_vals[i] = rand_ps();
      tick();
    end
    rst = 0; out_ready = 1;
    idle(N + 4);
    chk("final_empty", out_valid, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/psum_deskew_accum.md
Name: psum_deskew_accum

Overview:
- Sits directly downstream of the systolic array and consumes its bottom-row `partial_sum_flat` outputs.
- Those outputs arrive column-skewed: column j lags column 0 by j cycles. This block realigns each row, then accumulates it into an on-chip accumulator row buffer across K-dimension tiles.
- Completed rows are emitted through a valid/ready interface to the writeback stage.
- The array cannot stall, so the input side has no backpressure. Output congestion is reported through a sticky error flag.

Parameters:
- SYSTOLIC_SIZE, 8, array dimension N (number of columns).
- PARTIAL_SUM_WIDTH, 19, width of one array column output: WEIGHT_WIDTH + ACTIVATION_WIDTH + clog2(N), signed two's complement.
- ACC_WIDTH, 32, accumulator width per column, signed.
- ACC_DEPTH, 16, number of accumulator row entries.
- ADDR_WIDTH, clog2(ACC_DEPTH), row address width.

Ports:
- clk, in, 1, single clock.
- rst, in, 1, synchronous active-high reset.
- in_valid, in, 1, a row starts this cycle (qualifies column 0 now, and column j at +j cycles).
- in_first, in, 1, with in_valid: overwrite the entry instead of accumulating.
- in_last, in, 1, with in_valid: emit the entry after this update.
- in_addr, in, ADDR_WIDTH, accumulator entry for this row.
- partial_sum_flat, in, N*PARTIAL_SUM_WIDTH, array bottom-row outputs; column i at [i*PARTIAL_SUM_WIDTH +: PARTIAL_SUM_WIDTH].
- out_valid, out, 1, output FIFO non-empty.
- out_ready, in, 1, consumer accepts the head entry.
- out_addr, out, ADDR_WIDTH, entry address of the head row.
- out_data_flat, out, N*ACC_WIDTH, head row; column i at [i*ACC_WIDTH +: ACC_WIDTH].
- overflow_err, out, 1, sticky: a completed row was dropped.

Behaviour:
- Reset (rst=1 at an edge):
  - All deskew registers, sideband pipeline, accumulator entries and FIFO are cleared.
  - out_valid=0, out_addr=0, out_data_flat=0, overflow_err=0.
  - A reset mid-operation discards all in-flight rows; nothing partial is emitted afterwards.
- Deskew:
  - Column j passes through N-1-j delay registers, then into the align register. Column N-1 feeds the align register directly.
  - The sideband {in_valid, in_first, in_last, in_addr} passes through N-1 delay stages, then into the align register.
  - A row whose column 0 is sampled at edge E0 is fully aligned in the align register after edge E0+N-1.
  - partial_sum_flat is sampled every cycle regardless of in_valid. Column data is only used when the aligned valid bit is 1.
- Accumulate, at edge E0+N, when the aligned valid bit is 1:
  - If first: acc[addr][i] = sign_extend(ps_i).
  - Else: acc[addr][i] = acc[addr][i] + sign_extend(ps_i).
  - The sum wraps modulo 2^ACC_WIDTH; there is no saturation.
  - The read-modify-write completes in one cycle, so back-to-back rows to the same addr accumulate correctly with no hazard.
- Emit: if last at the same edge, {addr, new acc row} is pushed into a 2-entry FIFO.
  - first and last together means a single-tile row: overwrite, then emit.
  - The acc entry keeps its value after emit.
- Latency: out_valid rises after edge E0+N when the FIFO was empty, i.e. N cycles from column-0 sample to output.
- FIFO:
  - Pop when out_valid && out_ready.
  - out_addr and out_data_flat are stable while out_valid=1 and out_ready=0.
  - Push when full with a simultaneous pop: accepted.
  - Push when full with no pop: row dropped, overflow_err set to 1, and it stays 1 until rst.
  - The accumulator is still updated on a dropped push.
- No state machine beyond the FIFO occupancy counter (0/1/2) and read/write pointers.

Decomposition:
- Shared package/header holds:
  - ACC_WIDTH default.
  - Deskew latency constant DESKEW_LAT = SYSTOLIC_SIZE-1.
  - Column slice index helper macros, shared with the array's input skew logic.
- Sub-module psum_deskew: the triangular per-column delay line plus sideband delay. It is reused later for the activation input skew.
- The accumulator array and FIFO stay in the top module.

Test Plan:
- Single tile, N=8, in_valid/first/last=1, addr=3, column i ramp values = i+1 with correct skew → exactly 8 cycles later out_valid=1, out_addr=3, out_data column i = i+1.
- Three tiles to addr=5, each column=-2 (0x7FFFE), first on tile 1, last on tile 3, rows back-to-back → one output, each column = -6 (0xFFFFFFFA), zero-extension bug absent.
- Back-to-back rows alternating addr 0/1, four tiles each with value 10 → outputs addr 0 then addr 1, each column 40; no lost updates from the same-cycle RMW.
- out_ready=0, three consecutive single-tile rows → first two held in FIFO, third dropped, overflow_err=1 and held; release out_ready → two rows out in order, then out_valid=0.
- Full FIFO with out_ready=1 in the same cycle as a third push → no drop, overflow_err stays 0.
- Assert rst 3 cycles after a row's in_valid → no out_valid ever appears for that row; a subsequent non-first accumulate to that addr of value 7 → emits 7 (acc reset to 0).
